// File: rtl/phys_reg_file_sb.sv
// Physical register file with ready-bit scoreboard, write-first bypass, selectable read
// latency and write-port collision tracking. All ports are enable-qualified with no back-pressure.
module phys_reg_file_sb #(
  parameter int WORD_SIZE       = 64,
  parameter int NUM_PHYS_REGS   = 128,
  parameter int NUM_READ_PORTS  = 6,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int NUM_ALLOC_PORTS = 2,
  parameter int READ_LATENCY    = 1,
  parameter int ZERO_REG        = 1,
  localparam int IDX_W          = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_READ_PORTS-1:0]                       read_en,
  input  logic [NUM_READ_PORTS-1:0][IDX_W-1:0]            read_index,
  output logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0]        read_data,
  output logic [NUM_READ_PORTS-1:0]                       read_ready,
  input  logic [NUM_WRITE_PORTS-1:0]                      write_en,
  input  logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]           write_index,
  input  logic [NUM_WRITE_PORTS-1:0][WORD_SIZE-1:0]       write_data,
  input  logic                                            nzcv_valid,
  input  logic [IDX_W-1:0]                                nzcv_index,
  input  logic [3:0]                                      nzcv_data,
  input  logic [NUM_ALLOC_PORTS-1:0]                      alloc_en,
  input  logic [NUM_ALLOC_PORTS-1:0][IDX_W-1:0]           alloc_index,
  input  logic                                            flush,
  output logic                                            write_conflict,
  output logic [7:0]                                      conflict_count
);

  // Writer 0 is NZCV, writer k+1 is write port k; a higher writer index wins.
  localparam int NW = NUM_WRITE_PORTS + 1;

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $error("phys_reg_file_sb: READ_LATENCY must be 0 or 1");
  end

  function automatic logic is_zero(input logic [IDX_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  logic [WORD_SIZE-1:0]                   mem [NUM_PHYS_REGS];
  logic [NUM_PHYS_REGS-1:0]               rdy, rdy_next;
  logic [NW-1:0]                          wr_live;
  logic [NW-1:0][IDX_W-1:0]               wr_idx;
  logic [NW-1:0][WORD_SIZE-1:0]           wr_data;
  logic                                   conflict;
  logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0] eff_data;
  logic [NUM_READ_PORTS-1:0]              eff_rdy;

  // Writes to a hardwired zero register are dropped before anything else sees them.
  always_comb begin
    wr_idx[0]  = nzcv_index;
    wr_data[0] = WORD_SIZE'(nzcv_data);
    wr_live[0] = nzcv_valid && !is_zero(nzcv_index);
    for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
      wr_idx[k+1]  = write_index[k];
      wr_data[k+1] = write_data[k];
      wr_live[k+1] = write_en[k] && !is_zero(write_index[k]);
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int a = 0; a < NW; a++) begin
      for (int b = a + 1; b < NW; b++) begin
        if (wr_live[a] && wr_live[b] && (wr_idx[a] == wr_idx[b])) conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_live[k]) mem[wr_idx[k]] <= wr_data[k];
      end
    end
  end

  // Ready precedence: alloc over write over flush, applied in reverse order.
  always_comb begin
    rdy_next = flush ? '1 : rdy;
    for (int k = 0; k < NW; k++) begin
      if (wr_live[k]) rdy_next[wr_idx[k]] = 1'b1;
    end
    for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
      if (alloc_en[a] && !is_zero(alloc_index[a])) rdy_next[alloc_index[a]] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy <= '1;
    else        rdy <= rdy_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_conflict <= 1'b0;
      conflict_count <= 8'd0;
    end else if (conflict) begin
      write_conflict <= 1'b1;
      if (conflict_count != 8'hFF) conflict_count <= conflict_count + 8'd1;
    end
  end

  // Write-first bypass; same-cycle allocs deliberately do not affect the ready seen here.
  always_comb begin
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      eff_data[r] = mem[read_index[r]];
      eff_rdy[r]  = rdy[read_index[r]];
      for (int k = 0; k < NW; k++) begin
        if (wr_live[k] && (wr_idx[k] == read_index[r])) begin
          eff_data[r] = wr_data[k];
          eff_rdy[r]  = 1'b1;
        end
      end
      if (is_zero(read_index[r])) begin
        eff_data[r] = '0;
        eff_rdy[r]  = 1'b1;
      end
      if (!read_en[r]) begin
        eff_data[r] = '0;
        eff_rdy[r]  = 1'b0;
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    assign read_data  = eff_data;
    assign read_ready = eff_rdy;
  end else begin : g_reg_read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        read_data  <= '0;
        read_ready <= '0;
      end else begin
        read_data  <= eff_data;
        read_ready <= eff_rdy;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_file_sb.sv
// Bench for phys_reg_file_sb: a latency-0 and a latency-1 instance share stimulus and are
// compared against an array-based reference model of the register file and scoreboard.
module tb_phys_reg_file_sb;
  localparam int WS = 64;
  localparam int NP = 128;
  localparam int IW = 7;
  localparam int R  = 6;
  localparam int W  = 4;
  localparam int A  = 2;

  logic                 clk, rst_n;
  logic [R-1:0]         read_en;
  logic [R-1:0][IW-1:0] read_index;
  logic [W-1:0]         write_en;
  logic [W-1:0][IW-1:0] write_index;
  logic [W-1:0][WS-1:0] write_data;
  logic                 nzcv_valid;
  logic [IW-1:0]        nzcv_index;
  logic [3:0]           nzcv_data;
  logic [A-1:0]         alloc_en;
  logic [A-1:0][IW-1:0] alloc_index;
  logic                 flush;

  logic [R-1:0][WS-1:0] d0_data, d1_data;
  logic [R-1:0]         d0_rdy, d1_rdy;
  logic                 d0_conf, d1_conf;
  logic [7:0]           d0_cnt, d1_cnt;

  // reference model state
  logic [WS-1:0] m_mem [NP];
  bit   [NP-1:0] m_rdy;
  bit            m_conf;
  int            m_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  phys_reg_file_sb #(.READ_LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_index(read_index),
    .read_data(d0_data), .read_ready(d0_rdy), .write_en(write_en),
    .write_index(write_index), .write_data(write_data), .nzcv_valid(nzcv_valid),
    .nzcv_index(nzcv_index), .nzcv_data(nzcv_data), .alloc_en(alloc_en),
    .alloc_index(alloc_index), .flush(flush), .write_conflict(d0_conf),
    .conflict_count(d0_cnt)
  );

  phys_reg_file_sb #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_index(read_index),
    .read_data(d1_data), .read_ready(d1_rdy), .write_en(write_en),
    .write_index(write_index), .write_data(write_data), .nzcv_valid(nzcv_valid),
    .nzcv_index(nzcv_index), .nzcv_data(nzcv_data), .alloc_en(alloc_en),
    .alloc_index(alloc_index), .flush(flush), .write_conflict(d1_conf),
    .conflict_count(d1_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value/ready an index shows this cycle: highest-priority writer first, NZCV last.
  function automatic void eff(input logic [IW-1:0] idx, output logic [63:0] d, output logic r);
    d = m_mem[idx];
    r = m_rdy[idx];
    if (idx == 0) begin
      d = '0;
      r = 1'b1;
      return;
    end
    for (int k = W - 1; k >= 0; k--) begin
      if (write_en[k] && write_index[k] == idx) begin
        d = write_data[k];
        r = 1'b1;
        return;
      end
    end
    if (nzcv_valid && nzcv_index == idx) begin
      d = {60'b0, nzcv_data};
      r = 1'b1;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_mem[i] = '0;
    m_rdy  = '1;
    m_conf = 0;
    m_cnt  = 0;
  endtask

  task automatic model_clock();
    int            hits[int];
    logic [63:0]   win[int];
    logic          rtmp;
    if (nzcv_valid && nzcv_index != 0) hits[int'(nzcv_index)]++;
    for (int k = 0; k < W; k++)
      if (write_en[k] && write_index[k] != 0) hits[int'(write_index[k])]++;
    foreach (hits[i]) eff(IW'(i), win[i], rtmp);
    if (flush) m_rdy = '1;
    foreach (hits[i]) begin
      m_mem[i] = win[i];
      m_rdy[i] = 1'b1;
      if (hits[i] >= 2) begin
        m_conf = 1;
      end
    end
    foreach (hits[i]) begin
      if (hits[i] >= 2) begin
        if (m_cnt < 255) m_cnt++;
        break;
      end
    end
    for (int a = 0; a < A; a++)
      if (alloc_en[a] && alloc_index[a] != 0) m_rdy[alloc_index[a]] = 1'b0;
  endtask

  task automatic idle_inputs();
    read_en = '0; read_index = '0;
    write_en = '0; write_index = '0; write_data = '0;
    nzcv_valid = 0; nzcv_index = '0; nzcv_data = '0;
    alloc_en = '0; alloc_index = '0; flush = 0;
  endtask

  // Entered right after a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    logic [63:0] ed[R];
    logic        er[R];
    #1;
    for (int r = 0; r < R; r++) begin
      if (read_en[r]) eff(read_index[r], ed[r], er[r]);
      else begin ed[r] = '0; er[r] = 1'b0; end
      chk($sformatf("l0_data%0d", r), d0_data[r], ed[r]);
      chk($sformatf("l0_rdy%0d", r), 64'(d0_rdy[r]), 64'(er[r]));
    end
    @(posedge clk);
    model_clock();
    #1;
    for (int r = 0; r < R; r++) begin
      chk($sformatf("l1_data%0d", r), d1_data[r], ed[r]);
      chk($sformatf("l1_rdy%0d", r), 64'(d1_rdy[r]), 64'(er[r]));
    end
    chk("conf_l1", 64'(d1_conf), 64'(m_conf));
    chk("cnt_l1", 64'(d1_cnt), 64'(m_cnt));
    chk("conf_l0", 64'(d0_conf), 64'(m_conf));
    chk("cnt_l0", 64'(d0_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", d1_data, '0);
    chk("rst_rdy", 64'(d1_rdy), 64'd0);
    chk("rst_conf", 64'(d1_conf), 64'd0);
    chk("rst_cnt", 64'(d1_cnt), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    do_reset();

    // 1: read preg 5 after reset
    read_en[0] = 1; read_index[0] = 7'd5;
    cycle();
    chk("t1_data", d1_data[0], 64'd0);
    chk("t1_rdy", 64'(d1_rdy[0]), 64'd1);
    chk("t1_conf", 64'(d1_conf), 64'd0);

    // 2: alloc 9, read not ready, write port 2 bypass, value persists
    idle_inputs();
    alloc_en[0] = 1; alloc_index[0] = 7'd9;
    cycle();
    idle_inputs();
    read_en[1] = 1; read_index[1] = 7'd9;
    cycle();
    chk("t2_notrdy", 64'(d1_rdy[1]), 64'd0);
    write_en[2] = 1; write_index[2] = 7'd9; write_data[2] = 64'hDEAD;
    #1;
    chk("t2_byp_data", d0_data[1], 64'hDEAD);
    chk("t2_byp_rdy", 64'(d0_rdy[1]), 64'd1);
    cycle();
    idle_inputs();
    read_en[1] = 1; read_index[1] = 7'd9;
    cycle();
    chk("t2_persist", d1_data[1], 64'hDEAD);

    // 3: ports 0 and 3 collide on preg 7, then saturate the counter
    idle_inputs();
    write_en = 4'b1001; write_index[0] = 7'd7; write_index[3] = 7'd7;
    write_data[0] = 64'h11; write_data[3] = 64'h33;
    cycle();
    chk("t3_conf", 64'(d1_conf), 64'd1);
    chk("t3_cnt1", 64'(d1_cnt), 64'd1);
    read_en[0] = 1; read_index[0] = 7'd7;
    for (int i = 0; i < 299; i++) cycle();
    chk("t3_data", d1_data[0], 64'h33);
    chk("t3_sat", 64'(d1_cnt), 64'd255);

    // 4: NZCV writeback, then NZCV loses to port 0
    idle_inputs();
    nzcv_valid = 1; nzcv_index = 7'd12; nzcv_data = 4'b1010;
    cycle();
    idle_inputs();
    read_en[2] = 1; read_index[2] = 7'd12;
    cycle();
    chk("t4_nzcv", d1_data[2], 64'hA);
    chk("t4_rdy", 64'(d1_rdy[2]), 64'd1);
    nzcv_valid = 1; nzcv_index = 7'd12; nzcv_data = 4'b1111;
    write_en[0] = 1; write_index[0] = 7'd12; write_data[0] = 64'h5;
    cycle();
    idle_inputs();
    read_en[2] = 1; read_index[2] = 7'd12;
    cycle();
    chk("t4_prio", d1_data[2], 64'h5);

    // 5: allocs beat flush and write; everything else ends up ready
    idle_inputs();
    alloc_en[0] = 1; alloc_index[0] = 7'd30;
    cycle();
    idle_inputs();
    alloc_en = 2'b11; alloc_index[0] = 7'd20; alloc_index[1] = 7'd21;
    flush = 1;
    write_en[0] = 1; write_index[0] = 7'd20; write_data[0] = 64'hBEEF;
    cycle();
    idle_inputs();
    read_en = '1;
    for (int base = 0; base < NP; base += R) begin
      for (int r = 0; r < R; r++) read_index[r] = IW'((base + r) % NP);
      cycle();
    end
    idle_inputs();
    read_en[0] = 1; read_index[0] = 7'd20;
    read_en[1] = 1; read_index[1] = 7'd21;
    read_en[2] = 1; read_index[2] = 7'd30;
    cycle();
    chk("t5_r20_data", d1_data[0], 64'hBEEF);
    chk("t5_r20_rdy", 64'(d1_rdy[0]), 64'd0);
    chk("t5_r21_rdy", 64'(d1_rdy[1]), 64'd0);
    chk("t5_r30_rdy", 64'(d1_rdy[2]), 64'd1);

    // randomized traffic over a small index window to provoke collisions and preg 0 hits
    do_reset();
    for (int c = 0; c < 250; c++) begin
      idle_inputs();
      for (int r = 0; r < R; r++) begin
        read_en[r] = 1'($urandom_range(0, 3) != 0);
        read_index[r] = IW'($urandom_range(0, 15));
      end
      for (int k = 0; k < W; k++) begin
        write_en[k] = 1'($urandom_range(0, 2) == 0);
        write_index[k] = IW'($urandom_range(0, 15));
        write_data[k] = {$urandom, $urandom};
      end
      nzcv_valid = 1'($urandom_range(0, 3) == 0);
      nzcv_index = IW'($urandom_range(0, 15));
      nzcv_data = 4'($urandom);
      for (int a = 0; a < A; a++) begin
        alloc_en[a] = 1'($urandom_range(0, 2) == 0);
        alloc_index[a] = IW'($urandom_range(0, 15));
      end
      flush = 1'($urandom_range(0, 15) == 0);
      cycle();
    end

    // 6: preg 0 writes dropped, then asynchronous reset between edges
    idle_inputs();
    write_en[1] = 1; write_index[1] = 7'd0; write_data[1] = 64'hFF;
    write_en[0] = 1; write_index[0] = 7'd40; write_data[0] = 64'h1234;
    read_en[0] = 1; read_index[0] = 7'd0;
    cycle();
    chk("t6_zero_data", d1_data[0], 64'd0);
    chk("t6_zero_rdy", 64'(d1_rdy[0]), 64'd1);
    idle_inputs();
    read_en[0] = 1; read_index[0] = 7'd40;
    cycle();
    chk("t6_r40", d1_data[0], 64'h1234);
    write_en[2] = 1; write_index[2] = 7'd41; write_data[2] = 64'h77;
    write_en[3] = 1; write_index[3] = 7'd41; write_data[3] = 64'h78;
    #2;
    rst_n = 1'b0;
    write_en = '0;
    #1;
    chk("t6_async_l1_data", d1_data[0], 64'd0);
    chk("t6_async_l1_rdy", 64'(d1_rdy[0]), 64'd0);
    chk("t6_async_l0_data", d0_data[0], 64'd0);
    chk("t6_async_l0_rdy", 64'(d0_rdy[0]), 64'd1);
    chk("t6_async_conf", 64'(d1_conf), 64'd0);
    chk("t6_async_cnt", 64'(d1_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    read_en[0] = 1; read_index[0] = 7'd41;
    cycle();
    chk("t6_lost_write", d1_data[0], 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
